// File: rtl/spike_window_classifier_if.sv
// ============================================================================
// Module : spike_window_classifier_if
// Brief  : Control, spike-input and decision-output bundle of the classifier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface spike_window_classifier_if #(
    parameter int N_OUT = 2,
    parameter int CNT_W = 6,
    parameter int WIN_W = 6,
    parameter int CLS_W = 1
);
    logic                   enable;
    logic [WIN_W-1:0]       window_len;
    logic [N_OUT-1:0]       spikes_in;
    logic                   spikes_valid;
    logic [N_OUT*CNT_W-1:0] spike_counts_out;
    logic [CLS_W-1:0]       class_out;
    logic                   class_valid;
    logic                   tie;
    logic                   no_spike;
    logic                   busy;

    modport master (
        output enable, window_len, spikes_in, spikes_valid,
        input  spike_counts_out, class_out, class_valid, tie, no_spike, busy
    );

    modport slave (
        input  enable, window_len, spikes_in, spikes_valid,
        output spike_counts_out, class_out, class_valid, tie, no_spike, busy
    );
endinterface

`default_nettype wire

// File: rtl/spike_window_classifier.sv
// ============================================================================
// Module : spike_window_classifier
// Brief  : Counts output-layer spikes over a window of valid steps and emits
//          the argmax class with tie / no-spike flags. Optional macro
//          SPIKE_CLASSIFIER_CONTINUOUS_EN gives back-to-back windows.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spike_window_classifier #(
    parameter int N_OUT = 2,
    parameter int CNT_W = 6,
    parameter int WIN_W = 6,
    parameter int CLS_W = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    spike_window_classifier_if.slave   bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCUM  = 2'd1;
    localparam logic [1:0] c_DECIDE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [WIN_W:0]   c_SMP_ONE = (WIN_W+1)'(1);

    logic [1:0]                  state_q, state_d;
    logic [N_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W:0]              sample_cnt_q, sample_cnt_d;
    logic [WIN_W-1:0]            len_q, len_d;
    logic [CLS_W-1:0]            class_q, class_d;
    logic                        class_valid_q, class_valid_d;
    logic                        tie_q, tie_d;
    logic                        no_spike_q, no_spike_d;

    logic [N_OUT-1:0][CNT_W-1:0] w_acc;
    logic [CNT_W-1:0]            w_max;
    logic [CLS_W-1:0]            w_best;
    logic                        w_tie;
    logic                        w_last;
    logic                        w_decide;
    logic [WIN_W-1:0]            w_len_eff;

    assign w_len_eff = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
    assign w_last    = (sample_cnt_q == ({1'b0, len_q} - c_SMP_ONE));

    // Candidate counts for a decision: the saturating accumulation of this
    // cycle's sample, or the lone reload sample of a length-1 window in DECIDE.
    always_comb begin
        w_acc = cnt_q;
        for (int i = 0; i < N_OUT; i++) begin
`ifdef SPIKE_CLASSIFIER_CONTINUOUS_EN
            if (state_q == c_DECIDE) begin
                w_acc[i] = CNT_W'(bus.spikes_in[i]);
            end else
`endif
            if (bus.spikes_in[i] && (cnt_q[i] != c_CNT_MAX)) begin
                w_acc[i] = cnt_q[i] + c_CNT_ONE;
            end
        end
    end

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        w_max  = w_acc[0];
        w_best = '0;
        w_tie  = 1'b0;
        for (int i = 1; i < N_OUT; i++) begin
            if (w_acc[i] > w_max) begin
                w_max  = w_acc[i];
                w_best = CLS_W'(i);
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            if ((CLS_W'(i) != w_best) && (w_acc[i] == w_max)) begin
                w_tie = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sample_cnt_d  = sample_cnt_q;
        len_d         = len_q;
        w_decide      = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (bus.enable) begin
                    state_d      = c_ACCUM;
                    cnt_d        = '0;
                    sample_cnt_d = '0;
                    len_d        = w_len_eff;
                end
            end
            c_ACCUM: begin
                if (!bus.enable) begin
                    state_d      = c_IDLE;
                    cnt_d        = '0;
                    sample_cnt_d = '0;
                end else if (bus.spikes_valid) begin
                    cnt_d        = w_acc;
                    sample_cnt_d = sample_cnt_q + c_SMP_ONE;
                    if (w_last) begin
                        state_d  = c_DECIDE;
                        w_decide = 1'b1;
                    end
                end
            end
            c_DECIDE: begin
`ifdef SPIKE_CLASSIFIER_CONTINUOUS_EN
                if (bus.enable) begin
                    state_d      = c_ACCUM;
                    len_d        = w_len_eff;
                    sample_cnt_d = (WIN_W+1)'(bus.spikes_valid);
                    for (int i = 0; i < N_OUT; i++) begin
                        cnt_d[i] = CNT_W'(bus.spikes_in[i] & bus.spikes_valid);
                    end
                    if (bus.spikes_valid && (w_len_eff == WIN_W'(1))) begin
                        state_d  = c_DECIDE;
                        w_decide = 1'b1;
                    end
                end else begin
                    state_d = c_IDLE;
                end
`else
                state_d = c_DONE;
`endif
            end
            c_DONE: begin
                if (!bus.enable) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // The decision is registered on the edge that takes the final sample,
    // so the result is visible during the DECIDE cycle itself.
    always_comb begin
        class_d       = class_q;
        tie_d         = tie_q;
        no_spike_d    = no_spike_q;
        class_valid_d = w_decide;
        if (w_decide) begin
            class_d    = w_best;
            tie_d      = w_tie;
            no_spike_d = (w_max == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= c_IDLE;
            cnt_q         <= '0;
            sample_cnt_q  <= '0;
            len_q         <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            tie_q         <= 1'b0;
            no_spike_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            len_q         <= len_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            tie_q         <= tie_d;
            no_spike_q    <= no_spike_d;
        end
    end

    assign bus.spike_counts_out = cnt_q;
    assign bus.class_out        = class_q;
    assign bus.class_valid      = class_valid_q;
    assign bus.tie              = tie_q;
    assign bus.no_spike         = no_spike_q;
    assign bus.busy             = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spike_window_classifier.sv
// ============================================================================
// Module : tb_spike_window_classifier
// Brief  : Directed vector table plus hand sequences for the spike classifier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spike_window_classifier;
    localparam int N_OUT = 2;
    localparam int CNT_W = 6;
    localparam int WIN_W = 6;
    localparam int CLS_W = 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spike_window_classifier_if #(.N_OUT(N_OUT), .CNT_W(CNT_W), .WIN_W(WIN_W), .CLS_W(CLS_W)) bus ();

    spike_window_classifier #(.N_OUT(N_OUT), .CNT_W(CNT_W), .WIN_W(WIN_W), .CLS_W(CLS_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int             len;
        int             n;
        logic [3:0][1:0] s;
        int             cls;
        int             tie;
        int             ns;
        int             c0;
        int             c1;
        bit             chk_tie;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int c0();
        return int'(bus.spike_counts_out[CNT_W-1:0]);
    endfunction

    function automatic int c1();
        return int'(bus.spike_counts_out[2*CNT_W-1:CNT_W]);
    endfunction

    function automatic vec_t mk(input int len, input int n, input logic [7:0] s,
                                input int cls, input int tie, input int ns,
                                input int e0, input int e1, input bit chk_tie);
        vec_t v;
        v.len = len; v.n = n; v.s = s; v.cls = cls; v.tie = tie; v.ns = ns;
        v.c0 = e0; v.c1 = e1; v.chk_tie = chk_tie;
        return v;
    endfunction

    task automatic run_window(input vec_t v, input int idx);
        bus.window_len   = WIN_W'(v.len);
        bus.spikes_valid = 1'b0;
        bus.enable       = 1'b1;
        @(posedge clk); #1;
        check($sformatf("v%0d_start_busy", idx), 32'(bus.busy), 1);
        for (int k = 0; k < v.n; k++) begin
            bus.spikes_in    = v.s[k];
            bus.spikes_valid = 1'b1;
            @(posedge clk); #1;
            if (k < v.n - 1) check($sformatf("v%0d_early_valid", idx), 32'(bus.class_valid), 0);
        end
        check($sformatf("v%0d_class_valid", idx), 32'(bus.class_valid), 1);
        check($sformatf("v%0d_class", idx), 32'(bus.class_out), v.cls);
        check($sformatf("v%0d_no_spike", idx), 32'(bus.no_spike), v.ns);
        check($sformatf("v%0d_n0", idx), c0(), v.c0);
        check($sformatf("v%0d_n1", idx), c1(), v.c1);
        if (v.chk_tie) check($sformatf("v%0d_tie", idx), 32'(bus.tie), v.tie);
`ifdef SPIKE_CLASSIFIER_CONTINUOUS_EN
        bus.spikes_valid = 1'b0;
        bus.enable       = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d_pulse_end", idx), 32'(bus.class_valid), 0);
        check($sformatf("v%0d_idle", idx), 32'(bus.busy), 0);
`else
        bus.spikes_in    = 2'b11;
        bus.spikes_valid = 1'b1;
        @(posedge clk); #1;
        check($sformatf("v%0d_pulse_end", idx), 32'(bus.class_valid), 0);
        check($sformatf("v%0d_done_busy", idx), 32'(bus.busy), 1);
        check($sformatf("v%0d_done_n0", idx), c0(), v.c0);
        check($sformatf("v%0d_done_n1", idx), c1(), v.c1);
        @(posedge clk); #1;
        check($sformatf("v%0d_done_hold", idx), 32'(bus.busy), 1);
        bus.enable       = 1'b0;
        bus.spikes_valid = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d_idle", idx), 32'(bus.busy), 0);
        check($sformatf("v%0d_class_kept", idx), 32'(bus.class_out), v.cls);
`endif
    endtask

    vec_t vecs[5];

    initial begin
        int nv;
        bit seen;
        // Sample k of a vector sits at bits [2k+1:2k]; bit 0 of each is neuron 0.
        vecs[0] = mk(4, 4, {2'b00, 2'b11, 2'b01, 2'b01}, 0, 0, 0, 3, 1, 1'b1);
        vecs[1] = mk(2, 2, {4'b0000, 2'b11, 2'b11},      0, 1, 0, 2, 2, 1'b1);
        vecs[2] = mk(2, 2, {4'b0000, 2'b00, 2'b00},      0, 0, 1, 0, 0, 1'b0);
        vecs[3] = mk(0, 1, {6'b000000, 2'b10},           1, 0, 0, 0, 1, 1'b1);
        vecs[4] = mk(3, 3, {2'b00, 2'b01, 2'b10, 2'b10}, 1, 0, 0, 1, 2, 1'b1);

        reset_n          = 1'b0;
        bus.enable       = 1'b0;
        bus.window_len   = '0;
        bus.spikes_in    = '0;
        bus.spikes_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_class", 32'(bus.class_out), 0);
        check("rst_valid", 32'(bus.class_valid), 0);
        check("rst_counts", 32'(bus.spike_counts_out), 0);
        check("rst_flags", {30'd0, bus.tie, bus.no_spike}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_window(vecs[i], i);

        // Saturating window of 63 with a valid on every other cycle.
        bus.window_len   = 6'd63;
        bus.spikes_in    = 2'b10;
        bus.spikes_valid = 1'b0;
        bus.enable       = 1'b1;
        @(posedge clk); #1;
        nv   = 0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            bus.spikes_valid = (c % 2 == 0);
            @(posedge clk);
            if (bus.spikes_valid) nv++;
            #1;
            if (bus.class_valid) seen = 1'b1;
        end
        check("sat_decided", 32'(seen), 1);
        check("sat_valid_count", nv, 63);
        check("sat_class", 32'(bus.class_out), 1);
        check("sat_n1", c1(), 63);
        check("sat_n0", c0(), 0);
        check("sat_tie", 32'(bus.tie), 0);
        bus.spikes_valid = 1'b0;
        bus.enable       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_idle", 32'(bus.busy), 0);

        // Abort after 2 of 4 samples.
        bus.window_len = 6'd4;
        bus.enable     = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            bus.spikes_in    = 2'b01;
            bus.spikes_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_mid_n0", c0(), 2);
        bus.enable       = 1'b0;
        bus.spikes_valid = 1'b0;
        seen             = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.class_valid) seen = 1'b1;
        end
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_counts", 32'(bus.spike_counts_out), 0);
        check("abort_no_valid", 32'(seen), 0);
        check("abort_class_kept", 32'(bus.class_out), 1);

        // Asynchronous reset in the middle of ACCUM.
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.spikes_in    = 2'b11;
        bus.spikes_valid = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_n1", c1(), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_counts", 32'(bus.spike_counts_out), 0);
        check("arst_class", 32'(bus.class_out), 0);
        check("arst_valid_flags", {29'd0, bus.class_valid, bus.tie, bus.no_spike}, 0);
        bus.enable       = 1'b0;
        bus.spikes_valid = 1'b0;
        #4;
        reset_n = 1'b1;
        @(posedge clk); #1;

`ifdef SPIKE_CLASSIFIER_CONTINUOUS_EN
        begin
            int pulses;
            int last_c;
            bus.window_len   = 6'd3;
            bus.spikes_in    = 2'b10;
            bus.spikes_valid = 1'b1;
            bus.enable       = 1'b1;
            @(posedge clk); #1;
            pulses = 0;
            last_c = -1;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (bus.class_valid) begin
                    check("cont_n1", c1(), 3);
                    check("cont_class", 32'(bus.class_out), 1);
                    if (last_c >= 0) check("cont_period", c - last_c, 3);
                    last_c = c;
                    pulses++;
                end
            end
            check("cont_pulses", pulses, 4);
            bus.enable       = 1'b0;
            bus.spikes_valid = 1'b0;
            repeat (3) @(posedge clk);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
- Sits directly downstream of the three-layer SNN core.
- Consumes its per-step output spikes and its output_data_ready strobe.
- Counts spikes per output neuron over a programmable window of valid timesteps, then emits the winning class (argmax of counts) with a one-cycle valid pulse plus tie and no-spike flags.
- Its result drives the chip's classification output.

Parameters:
- N_OUT, 2: number of output neurons / classes.
- CNT_W, 6: per-neuron spike counter width; counters saturate.
- WIN_W, 6: width of the window-length input.
- CLS_W, 1: class index width, equal to clog2(N_OUT), minimum 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  level; high starts and keeps a window running, low aborts.
- window_len  input  WIN_W  number of valid timesteps per window; latched at window start.
- spikes_in  input  N_OUT  output spikes from the network core.
- spikes_valid  input  1  the network's output_data_ready; a spikes_in sample counts only when high.
- spike_counts_out  output  N_OUT*CNT_W  live counters; neuron i occupies [i*CNT_W +: CNT_W].
- class_out  output  CLS_W  winning class index; held until the next decision.
- class_valid  output  1  one-cycle pulse when class_out, tie and no_spike update.
- tie  output  1  more than one neuron shares the maximum count.
- no_spike  output  1  all counts were zero at decision time.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n low, async): state IDLE; all counters, sample count and latched length cleared; class_out=0; class_valid=0; tie=0; no_spike=0; busy=0.
- FSM states: IDLE, ACCUM, DECIDE, DONE.
- IDLE:
  - enable=1 moves to ACCUM next cycle, clears counters and sample_cnt, and latches window_len.
  - A latched window_len of 0 is treated as 1.
  - spikes_valid is ignored in IDLE.
- ACCUM, on each cycle with spikes_valid=1:
  - counts[i] += spikes_in[i], saturating at 2^CNT_W-1.
  - sample_cnt increments.
  - When the sample just taken is sample number len (sample_cnt == len-1 before the increment), move to DECIDE.
- ACCUM abort: enable=0 moves to IDLE next cycle and clears counters; no class_valid; class_out and flags unchanged.
- DECIDE (exactly one cycle):
  - Registers argmax over the final counts into class_out.
  - Ties resolve to the lowest index; tie=1 if any other index equals the max.
  - no_spike=1 if every count is 0, with class_out=0.
  - class_valid=1 for this cycle only.
  - Next state is DONE, unless the optional feature is enabled.
- Latency: class_valid is asserted in the cycle after the clock edge that accepted the final valid sample.
- DONE: holds the counts; waits for enable=0, then moves to IDLE. A new window requires an enable low-then-high cycle.
- enable dropping during DECIDE: the decision still completes and class_valid still fires.
- spikes_valid during DECIDE or DONE is ignored, unless the optional feature is enabled.
- Saturation does not stop window counting; sample_cnt is WIN_W+1 bits wide and never wraps within a window.
- All outputs are registered except spike_counts_out and busy, which are direct register/state decodes.

Optional Feature:
- Macro: SPIKE_CLASSIFIER_CONTINUOUS_EN.
- Enabled: DECIDE transitions straight to ACCUM if enable=1, giving back-to-back windows.
  - The counters reload with the DECIDE-cycle sample (counts[i] = spikes_in[i] if spikes_valid, else 0; sample_cnt = spikes_valid), so no sample is lost.
  - window_len is re-latched in DECIDE.
  - If enable=0 in DECIDE, go to IDLE.
- Disabled: behaviour as above, via DONE; the DONE-to-IDLE handshake is mandatory.

Test Plan:
- Basic window: window_len=4, enable=1; valid samples spikes_in=01,01,11,00 -> counts {n1=1,n0=3}; class_out=0, tie=0, no_spike=0; class_valid high for 1 cycle, one cycle after the 4th valid; then DONE and busy=1 until enable falls.
- Tie and empty windows:
  - window_len=2 with samples 11,11 -> class_out=0, tie=1.
  - A separate window of 2 samples of 00 -> no_spike=1, class_out=0.
- Gapped valids and saturation: window_len=63, CNT_W=6, spikes_in=10 on every valid, spikes_valid toggling every other cycle -> n1 reaches 63 and stays there; decision occurs after exactly 63 valids; class_out=1.
- Abort and reset:
  - enable dropped after 2 of 4 samples -> IDLE, counts 0, no class_valid, prior class_out retained.
  - reset_n pulsed low mid-ACCUM, asynchronous to clk -> all outputs 0 immediately.
- window_len=0 -> treated as 1; decision follows the first valid sample.
- With SPIKE_CLASSIFIER_CONTINUOUS_EN: window_len=3, spikes_valid held high, spikes_in=10 -> class_valid every 3 cycles; no sample dropped, so counts show n1=3 each window; class_out=1.
